// File: rtl/ram_pkg.sv
// Shared types and constants for the asynchronous-RAM access sequencer.
package ram_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;

  localparam int DEF_SETUP_CYCLES = 1;
  localparam int DEF_PULSE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES  = 1;
  localparam int DEF_READ_CYCLES  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_READ,
    ST_RESP
  } ram_state_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // A single wait state still needs a one-bit counter.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles <= 1) ? 1 : $clog2(max_cycles);
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Down-counter shared by all timed states; done is high while the count is zero.
module wait_counter #(
  parameter int CNT_W = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer owning the control pins of a 256x8 asynchronous RAM; single-byte
// requests in over valid/ready, registered strobes out with programmable wait states.
module ram_access_ctrl
  import ram_pkg::*;
#(
  parameter int SETUP_CYCLES = DEF_SETUP_CYCLES,
  parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int READ_CYCLES  = DEF_READ_CYCLES
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_reqValid,
  output logic                  o_reqReady,
  input  logic                  i_reqWrite,
  input  logic [RAM_ADDR_W-1:0] i_reqAddr,
  input  logic [RAM_DATA_W-1:0] i_reqData,
  output logic                  o_rspValid,
  output logic [RAM_DATA_W-1:0] o_rspData,
  output logic [RAM_ADDR_W-1:0] o_ramAddress,
  output logic                  o_ramWriteNEn,
  output logic [RAM_DATA_W-1:0] o_ramWriteData,
  input  logic [RAM_DATA_W-1:0] i_ramReadData,
  output logic                  o_ramNoe
);

  localparam int CNT_W = cnt_width(max4(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, READ_CYCLES));

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYCLES - 1);

  ram_state_t              state_q;
  logic                    wen_q;
  logic                    noe_q;
  logic                    rsp_valid_q;
  logic [RAM_DATA_W-1:0]   rsp_data_q;
  logic [RAM_ADDR_W-1:0]   addr_q;
  logic [RAM_DATA_W-1:0]   wdata_q;

  logic                    cnt_load;
  logic [CNT_W-1:0]        cnt_load_val;
  logic                    cnt_done;

  // Counter is reloaded on the same edge that enters each timed state.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_reqValid) begin
          cnt_load     = 1'b1;
          cnt_load_val = i_reqWrite ? SETUP_LD : READ_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LD;
        end
      end
      ST_PULSE: begin
        if (cnt_done) begin
          cnt_load     = 1'b1;
          cnt_load_val = HOLD_LD;
        end
      end
      default: begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
      end
    endcase
  end

  wait_counter #(
    .CNT_W (CNT_W)
  ) u_wait_counter (
    .clk_i      (i_clk),
    .rst_ni     (i_nrst),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .done_o     (cnt_done)
  );

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      wen_q       <= 1'b1;
      noe_q       <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_reqValid) begin
            addr_q  <= i_reqAddr;
            wdata_q <= i_reqData;
            if (i_reqWrite) begin
              state_q <= ST_SETUP;
            end else begin
              state_q <= ST_READ;
              noe_q   <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          if (cnt_done) begin
            state_q <= ST_PULSE;
            wen_q   <= 1'b0;
          end
        end
        ST_PULSE: begin
          if (cnt_done) begin
            state_q <= ST_HOLD;
            wen_q   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt_done) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end
        end
        ST_READ: begin
          // Sample while output-enable is still low, then release the bus.
          if (cnt_done) begin
            state_q     <= ST_RESP;
            noe_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= i_ramReadData;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          wen_q   <= 1'b1;
          noe_q   <= 1'b1;
        end
      endcase
    end
  end

  assign o_reqReady     = (state_q == ST_IDLE);
  assign o_rspValid     = rsp_valid_q;
  assign o_rspData      = rsp_data_q;
  assign o_ramAddress   = addr_q;
  assign o_ramWriteData = wdata_q;
  assign o_ramWriteNEn  = wen_q;
  assign o_ramNoe       = noe_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: default timing instance (A) and a
// stretched-timing instance (B), each with a behavioural 256x8 RAM attached.
module tb_ram_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_nrst, a_valid, a_ready, a_write, a_rspv, a_wen, a_noe;
  logic [7:0] a_addr, a_data, a_rspd, a_ramA, a_wd, a_rd;
  logic       b_nrst, b_valid, b_ready, b_write, b_rspv, b_wen, b_noe;
  logic [7:0] b_addr, b_data, b_rspd, b_ramA, b_wd, b_rd;

  logic [7:0] a_mem [256];
  logic [7:0] b_mem [256];

  ram_access_ctrl ua (
    .i_clk(clk), .i_nrst(a_nrst), .i_reqValid(a_valid), .o_reqReady(a_ready),
    .i_reqWrite(a_write), .i_reqAddr(a_addr), .i_reqData(a_data),
    .o_rspValid(a_rspv), .o_rspData(a_rspd), .o_ramAddress(a_ramA),
    .o_ramWriteNEn(a_wen), .o_ramWriteData(a_wd), .i_ramReadData(a_rd),
    .o_ramNoe(a_noe)
  );

  ram_access_ctrl #(
    .SETUP_CYCLES(3), .PULSE_CYCLES(1), .HOLD_CYCLES(2), .READ_CYCLES(4)
  ) ub (
    .i_clk(clk), .i_nrst(b_nrst), .i_reqValid(b_valid), .o_reqReady(b_ready),
    .i_reqWrite(b_write), .i_reqAddr(b_addr), .i_reqData(b_data),
    .o_rspValid(b_rspv), .o_rspData(b_rspd), .o_ramAddress(b_ramA),
    .o_ramWriteNEn(b_wen), .o_ramWriteData(b_wd), .i_ramReadData(b_rd),
    .o_ramNoe(b_noe)
  );

  assign a_rd = a_noe ? 8'h00 : a_mem[a_ramA];
  assign b_rd = b_noe ? 8'h00 : b_mem[b_ramA];

  initial begin
    for (int i = 0; i < 256; i++) begin
      a_mem[i] = 8'(i) ^ 8'hC3;
      b_mem[i] = 8'(i) ^ 8'hC3;
    end
    forever begin
      @(posedge clk);
      if (!a_wen) a_mem[a_ramA] = a_wd;
      if (!b_wen) b_mem[b_ramA] = b_wd;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  int wen_first, wen_cnt, wen_last, noe_first, noe_cnt;
  int rsp_first, rsp_cnt, rdy_first, rdy_cnt, addr_stable;
  logic [7:0] rsp_data;
  logic [7:0] addr_t [16];
  logic [7:0] rdat_t [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample n cycles starting with the current one (index 0 = just after accept).
  task automatic trace(input bit useb, input int n);
    logic       wen, noe, rsp, rdy;
    logic [7:0] adr, rdat, wen_addr;
    wen_first = -1; wen_cnt = 0; wen_last = -1; noe_first = -1; noe_cnt = 0;
    rsp_first = -1; rsp_cnt = 0; rdy_first = -1; rdy_cnt = 0; addr_stable = 1;
    rsp_data = 8'h00; wen_addr = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      wen  = useb ? b_wen  : a_wen;
      noe  = useb ? b_noe  : a_noe;
      rsp  = useb ? b_rspv : a_rspv;
      rdy  = useb ? b_ready : a_ready;
      adr  = useb ? b_ramA : a_ramA;
      rdat = useb ? b_rspd : a_rspd;
      addr_t[k] = adr;
      rdat_t[k] = rdat;
      if (!wen) begin
        if (wen_first < 0) begin
          wen_first = k;
          wen_addr  = adr;
        end else if (adr !== wen_addr) begin
          addr_stable = 0;
        end
        wen_cnt++;
        wen_last = k;
      end
      if (!noe) begin
        if (noe_first < 0) noe_first = k;
        noe_cnt++;
      end
      if (rsp) begin
        if (rsp_first < 0) begin
          rsp_first = k;
          rsp_data  = rdat;
        end
        rsp_cnt++;
      end
      if (rdy) begin
        if (rdy_first < 0) rdy_first = k;
        rdy_cnt++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_nrst = 1'b0; a_valid = 1'b0; a_write = 1'b0; a_addr = 8'h00; a_data = 8'h00;
    b_nrst = 1'b0; b_valid = 1'b0; b_write = 1'b0; b_addr = 8'h00; b_data = 8'h00;
    tick();
    tick();

    // Reset state
    chk("rst_wen", a_wen, 1);
    chk("rst_noe", a_noe, 1);
    chk("rst_addr", a_ramA, 8'h00);
    chk("rst_wdata", a_wd, 8'h00);
    chk("rst_rspv", a_rspv, 0);
    chk("rst_rspd", a_rspd, 8'h00);
    chk("rst_b_wen", b_wen, 1);
    chk("rst_b_noe", b_noe, 1);
    a_nrst = 1'b1;
    b_nrst = 1'b1;
    tick();
    chk("rst_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);

    // Write 0xA5 to 0x3C
    a_valid = 1'b1; a_write = 1'b1; a_addr = 8'h3C; a_data = 8'hA5;
    tick();
    a_valid = 1'b0;
    chk("wr_addr", a_ramA, 8'h3C);
    chk("wr_wdata", a_wd, 8'hA5);
    chk("wr_busy", a_ready, 0);
    trace(0, 8);
    chk("wr_wen_first", wen_first, 1);
    chk("wr_wen_cnt", wen_cnt, 2);
    chk("wr_wen_last", wen_last, 2);
    chk("wr_rsp_first", rsp_first, 4);
    chk("wr_rsp_cnt", rsp_cnt, 1);
    chk("wr_noe_cnt", noe_cnt, 0);
    chk("wr_rdy_first", rdy_first, 5);
    chk("wr_rspd_kept", rsp_data, 8'h00);
    chk("wr_mem", a_mem[8'h3C], 8'hA5);

    // Read 0x3C back
    a_valid = 1'b1; a_write = 1'b0; a_addr = 8'h3C; a_data = 8'h00;
    tick();
    a_valid = 1'b0;
    trace(0, 6);
    chk("rd_noe_first", noe_first, 0);
    chk("rd_noe_cnt", noe_cnt, 2);
    chk("rd_rsp_first", rsp_first, 2);
    chk("rd_rsp_cnt", rsp_cnt, 1);
    chk("rd_data", rsp_data, 8'hA5);
    chk("rd_wen_cnt", wen_cnt, 0);

    // Back-to-back: write 0x11 to 0x00, then read 0xFF, valid held high
    a_valid = 1'b1; a_write = 1'b1; a_addr = 8'h00; a_data = 8'h11;
    tick();
    a_write = 1'b0; a_addr = 8'hFF; a_data = 8'h00;
    trace(0, 9);
    a_valid = 1'b0;
    chk("b2b_rsp_first", rsp_first, 4);
    chk("b2b_rsp_cnt", rsp_cnt, 2);
    chk("b2b_rdy_first", rdy_first, 5);
    chk("b2b_rdy_cnt", rdy_cnt, 1);
    chk("b2b_wen_cnt", wen_cnt, 2);
    chk("b2b_addr_stable", addr_stable, 1);
    chk("b2b_addr_idle", addr_t[5], 8'h00);
    chk("b2b_addr_rd", addr_t[6], 8'hFF);
    chk("b2b_noe_first", noe_first, 6);
    chk("b2b_noe_cnt", noe_cnt, 2);
    chk("b2b_rd_data", rdat_t[8], 8'h3C);
    chk("b2b_mem", a_mem[8'h00], 8'h11);
    tick();

    // Reset asserted mid-PULSE
    a_valid = 1'b1; a_write = 1'b1; a_addr = 8'h55; a_data = 8'h77;
    tick();
    a_valid = 1'b0;
    tick();
    chk("mid_wen_low", a_wen, 0);
    #2;
    a_nrst = 1'b0;
    #1;
    chk("mid_wen_async", a_wen, 1);
    chk("mid_noe_async", a_noe, 1);
    chk("mid_rspv", a_rspv, 0);
    tick();
    a_nrst = 1'b1;
    trace(0, 6);
    chk("mid_no_rsp", rsp_cnt, 0);
    chk("mid_no_wen", wen_cnt, 0);
    chk("mid_ready", rdy_cnt, 6);
    a_valid = 1'b1; a_write = 1'b1; a_addr = 8'h55; a_data = 8'h99;
    tick();
    a_valid = 1'b0;
    trace(0, 8);
    chk("post_rsp_first", rsp_first, 4);
    chk("post_wen_cnt", wen_cnt, 2);
    chk("post_mem", a_mem[8'h55], 8'h99);

    // Instance B: SETUP=3 PULSE=1 HOLD=2 READ=4
    b_valid = 1'b1; b_write = 1'b1; b_addr = 8'hFF; b_data = 8'hE7;
    tick();
    b_valid = 1'b0;
    trace(1, 10);
    chk("B_wr_wen_first", wen_first, 3);
    chk("B_wr_wen_cnt", wen_cnt, 1);
    chk("B_wr_rsp_first", rsp_first, 6);
    chk("B_wr_rdy_first", rdy_first, 7);
    chk("B_wr_addr_stable", addr_stable, 1);
    b_valid = 1'b1; b_write = 1'b0; b_addr = 8'hFF; b_data = 8'h00;
    tick();
    b_valid = 1'b0;
    trace(1, 8);
    chk("B_rd_noe_first", noe_first, 0);
    chk("B_rd_noe_cnt", noe_cnt, 4);
    chk("B_rd_rsp_first", rsp_first, 4);
    chk("B_rd_data", rsp_data, 8'hE7);
    chk("B_rd_wen_cnt", wen_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
